// File: rtl/conv_pre_pkg.sv
// rtl/conv_pre_pkg.sv - shared mode encodings and lane extension for the conv pre-process path
package conv_pre_pkg;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } mode_e;

  localparam int unsigned EXT_W  = 32;
  localparam int unsigned EXT_IW = 5;

  // Extend the low dw_in bits of data to EXT_W bits; callers truncate to their own lane width.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] data,
                                           input int unsigned      dw_in,
                                           input logic             sgn);
    logic [EXT_W-1:0] mask;
    logic             msb;
    mask = ~({EXT_W{1'b1}} << dw_in);
    msb  = sgn & data[EXT_IW'(dw_in - 1)];
    return (data & mask) | ({EXT_W{msb}} & ~mask);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - one lane delay line with runtime tap select and a travelling valid bit
module skew_delay_line #(
  parameter int DEPTH = 8,
  parameter int DW    = 9,
  parameter int TAPW  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            flush,
  input  logic [TAPW-1:0] tap,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            any_valid
);

  logic [DEPTH:1] v_q;
  logic [DW-1:0]  d_q [1:DEPTH];

  // Shift register: stage 1 takes the lane input, every stage moves one step per enabled cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      for (int i = 1; i <= DEPTH; i++) d_q[i] <= '0;
    end else if (flush) begin
      v_q <= '0;
      for (int i = 1; i <= DEPTH; i++) d_q[i] <= '0;
    end else if (en) begin
      v_q[1] <= in_valid;
      d_q[1] <= in_data;
      for (int i = 2; i <= DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  // Tap mux: tap 0 bypasses the line, tap n picks stage n.
  always_comb begin
    out_valid = in_valid;
    out_data  = in_data;
    for (int i = 1; i <= DEPTH; i++) begin
      if (tap == TAPW'(i)) begin
        out_valid = v_q[i];
        out_data  = d_q[i];
      end
    end
  end

  assign any_valid = |v_q;

endmodule

// File: rtl/conv_skew_align.sv
// rtl/conv_skew_align.sv - per-lane staircase skew/deskew aligner with extension and config latch
module conv_skew_align #(
  parameter int CH_NUM = 9,
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 9
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [CH_NUM*DW_IN-1:0]  in_data,
  input  logic                     cfg_deskew,
  input  logic                     cfg_signed,
  output logic [CH_NUM-1:0]        out_valid,
  output logic [CH_NUM*DW_OUT-1:0] out_data,
  output logic                     busy
);

  import conv_pre_pkg::*;

  localparam int TAPW = (CH_NUM > 2) ? $clog2(CH_NUM) : 1;

  mode_e             mode_q;
  logic              signed_q;
  mode_e             eff_mode;
  logic              eff_signed;
  logic [CH_NUM-1:0] busy_vec;

  // While anything is in flight the latched config steers the lanes, so mid-stream changes are ignored.
  assign eff_mode   = busy ? mode_q   : mode_e'(cfg_deskew);
  assign eff_signed = busy ? signed_q : cfg_signed;
  assign busy       = |busy_vec;

  // Config latch tracks the live inputs whenever the block is idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= SKEW;
      signed_q <= 1'b1;
    end else if (!busy) begin
      mode_q   <= mode_e'(cfg_deskew);
      signed_q <= cfg_signed;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    localparam logic [TAPW-1:0] TAP_SKEW   = TAPW'(k);
    localparam logic [TAPW-1:0] TAP_DESKEW = TAPW'(CH_NUM - 1 - k);

    logic [DW_OUT-1:0] ext_d;
    logic [TAPW-1:0]   tap;
    logic              dl_v;
    logic [DW_OUT-1:0] dl_d;
    logic              dl_any;
    logic              ov_q;
    logic [DW_OUT-1:0] od_q;

    // Extend at the lane input and zero bubble data so storage only ever holds beat contents.
    always_comb begin
      ext_d = '0;
      if (in_valid) begin
        ext_d = DW_OUT'(ext(EXT_W'(in_data[k*DW_IN +: DW_IN]), DW_IN, eff_signed));
      end
    end

    assign tap = (eff_mode == DESKEW) ? TAP_DESKEW : TAP_SKEW;

    skew_delay_line #(
      .DEPTH (CH_NUM - 1),
      .DW    (DW_OUT),
      .TAPW  (TAPW)
    ) u_dl (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .flush     (flush),
      .tap       (tap),
      .in_valid  (in_valid),
      .in_data   (ext_d),
      .out_valid (dl_v),
      .out_data  (dl_d),
      .any_valid (dl_any)
    );

    // Output register: one extra stage on every lane, data forced to 0 when not valid.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        ov_q <= 1'b0;
        od_q <= '0;
      end else if (flush) begin
        ov_q <= 1'b0;
        od_q <= '0;
      end else if (en) begin
        ov_q <= dl_v;
        od_q <= dl_v ? dl_d : '0;
      end
    end

    assign out_valid[k]                   = ov_q;
    assign out_data[k*DW_OUT +: DW_OUT]   = od_q;
    assign busy_vec[k]                    = dl_any | ov_q;
  end

endmodule

// File: tb/tb_conv_skew_align.sv
// tb/tb_conv_skew_align.sv - scoreboard bench for conv_skew_align
module tb_conv_skew_align;

  localparam int CH  = 9;
  localparam int DWI = 8;
  localparam int DWO = 9;

  logic                clk;
  logic                rstn;
  logic                en;
  logic                flush;
  logic                in_valid;
  logic [CH*DWI-1:0]   in_data;
  logic                cfg_deskew;
  logic                cfg_signed;
  logic [CH-1:0]       out_valid;
  logic [CH*DWO-1:0]   out_data;
  logic                busy;

  typedef struct {
    logic [DWO-1:0] data;
    int             due;
  } item_t;

  item_t sbq [CH][$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    en_cnt = 0;
  int    last_cnt = 0;
  logic  exp_mode;
  logic  exp_sgn;
  logic  mon_exp_v;
  item_t mon_it;
  item_t mdl_it;

  conv_skew_align #(
    .CH_NUM (CH),
    .DW_IN  (DWI),
    .DW_OUT (DWO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_deskew (cfg_deskew),
    .cfg_signed (cfg_signed),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DWO-1:0] tb_ext(input logic [DWI-1:0] x, input logic s);
    return {{(DWO-DWI){s & x[DWI-1]}}, x};
  endfunction

  function automatic logic [CH*DWI-1:0] build(input int base, input int step);
    logic [CH*DWI-1:0] d;
    for (int k = 0; k < CH; k++) d[k*DWI +: DWI] = DWI'(base + step * k);
    return d;
  endfunction

  // Model: push expected lane results with their due en-cycle count when a beat is accepted.
  always @(posedge clk) begin
    if (rstn) begin
      if (flush) begin
        for (int k = 0; k < CH; k++) sbq[k].delete();
      end else if (en) begin
        if (in_valid) begin
          for (int k = 0; k < CH; k++) begin
            mdl_it.data = tb_ext(in_data[k*DWI +: DWI], exp_sgn);
            mdl_it.due  = en_cnt + (exp_mode ? (CH - 1 - k) : k) + 1;
            sbq[k].push_back(mdl_it);
          end
        end
        en_cnt <= en_cnt + 1;
      end
    end
  end

  always @(negedge rstn) begin
    for (int k = 0; k < CH; k++) sbq[k].delete();
  end

  // Monitor: after every en-qualified edge, compare each lane against the scoreboard.
  always @(negedge clk) begin
    if (rstn && en_cnt != last_cnt) begin
      last_cnt <= en_cnt;
      for (int k = 0; k < CH; k++) begin
        mon_exp_v = (sbq[k].size() > 0) && (sbq[k][0].due == en_cnt);
        check($sformatf("lane%0d_valid@%0d", k, en_cnt), out_valid[k], mon_exp_v);
        if (mon_exp_v) begin
          mon_it = sbq[k].pop_front();
          check($sformatf("lane%0d_data@%0d", k, en_cnt), out_data[k*DWO +: DWO], mon_it.data);
        end else begin
          check($sformatf("lane%0d_zero@%0d", k, en_cnt), out_data[k*DWO +: DWO], '0);
        end
      end
    end
  end

  task automatic cyc(input logic e, input logic v, input logic f, input logic [CH*DWI-1:0] d,
                     input logic dsk, input logic sgn, input logic em, input logic es);
    en         = e;
    in_valid   = v;
    flush      = f;
    in_data    = d;
    cfg_deskew = dsk;
    cfg_signed = sgn;
    exp_mode   = em;
    exp_sgn    = es;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic dsk, input logic sgn);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, dsk, sgn, dsk, sgn);
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < CH; k++) check($sformatf("%s_q%0d", tag, k), sbq[k].size(), 0);
  endtask

  initial begin
    rstn       = 1'b0;
    en         = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    cfg_deskew = 1'b0;
    cfg_signed = 1'b1;
    exp_mode   = 1'b0;
    exp_sgn    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, '0);
    check("rst_data", |out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", dut.mode_q, 0);
    check("rst_signed", dut.signed_q, 1);
    rstn = 1'b1;
    @(negedge clk);

    // Skew, signed, all lanes 0x80.
    cyc(1, 1, 0, build(8'h80, 0), 0, 1, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      idle(1, 0, 1);
      check($sformatf("t2_busy%0d", i), busy, (i < 9) ? 1 : 0);
    end

    // Deskew, unsigned, lane k = k+1.
    cyc(1, 1, 0, build(1, 1), 1, 0, 1, 0);
    idle(10, 1, 0);
    check("t3_busy", busy, 0);
    check_drained("t3");

    // Stream of 20 beats with a 3-cycle stall in the middle.
    for (int b = 0; b < 20; b++) begin
      if (b == 10) begin
        for (int s = 0; s < 3; s++) cyc(0, 1, 0, build(8'hEE, 0), 0, 1, 0, 1);
      end
      cyc(1, 1, 0, build(b, 16), 0, 1, 0, 1);
    end
    idle(12, 0, 1);
    check_drained("t4");

    // Flush with in_valid in the same cycle.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, build(8'h30 + i, 1), 0, 1, 0, 1);
    cyc(1, 1, 1, build(8'h77, 0), 0, 1, 0, 1);
    check("t5_valid", out_valid, '0);
    check("t5_busy", busy, 0);
    check("t5_data", |out_data, 0);
    idle(12, 0, 1);
    // Flush while stalled.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, build(8'h50 + i, 2), 0, 1, 0, 1);
    cyc(0, 0, 1, '0, 0, 1, 0, 1);
    check("t5b_valid", out_valid, '0);
    check("t5b_busy", busy, 0);
    idle(12, 0, 1);
    check_drained("t5");

    // Config toggled while busy is ignored; toggled while idle applies to that beat.
    cyc(1, 1, 0, build(8'h80, 1), 0, 1, 0, 1);
    cyc(1, 1, 0, build(8'h90, 1), 1, 0, 0, 1);
    cyc(1, 1, 0, build(8'hA0, 1), 1, 0, 0, 1);
    idle(12, 0, 1);
    check("t6_busy", busy, 0);
    cyc(1, 1, 0, build(8'h85, 2), 1, 0, 1, 0);
    idle(12, 1, 0);
    check_drained("t6");

    // Reset mid-stream in deskew unsigned mode.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, build(8'hC0 + i, 3), 1, 0, 1, 0);
    #2 rstn = 1'b0;
    #1;
    check("t7_valid", out_valid, '0);
    check("t7_data", |out_data, 0);
    check("t7_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t7_mode", dut.mode_q, 0);
    check("t7_signed", dut.signed_q, 1);
    cyc(1, 1, 0, build(8'h91, 1), 0, 1, 0, 1);
    idle(12, 0, 1);
    check("t7_busy_end", busy, 0);
    check_drained("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_skew_align.md
# conv_skew_align

Parametrised per-channel skew/deskew aligner for the convolution pre-process path. It takes CH_NUM parallel DW_IN-bit lanes and delays each lane by a lane-dependent number of cycles: a staircase skew into the systolic multiplier array, or the inverse deskew on its output side. Each lane is sign- or zero-extended to DW_OUT bits, and a valid bit travels with every lane. Stall, flush and an idle-only configuration latch are supported.

## Interface
- CH_NUM, 9, number of lanes (≥2)
- DW_IN, 8, input lane width
- DW_OUT, 9, output lane width (≥ DW_IN)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  advance enable; 0 freezes all state
- flush  in  1  synchronous clear of pipeline contents
- in_valid  in  1  input beat valid
- in_data  in  CH_NUM*DW_IN  lane k at [k*DW_IN +: DW_IN]
- cfg_deskew  in  1  0: skew mode, 1: deskew mode
- cfg_signed  in  1  1: sign-extend, 0: zero-extend
- out_valid  out  CH_NUM  per-lane valid
- out_data  out  CH_NUM*DW_OUT  lane k at [k*DW_OUT +: DW_OUT]
- busy  out  1  any valid bit held anywhere in the block

## Operation
- Lane delay d_k is k in skew mode and CH_NUM-1-k in deskew mode. Every lane additionally passes through one output register.
- A beat is accepted when en=1 and in_valid=1. When en=1 and in_valid=0, a bubble enters: its valid bit is 0 and its data is 0.
- en=0: all shift, valid and output registers hold their values. Input is ignored.
- flush=1: on the next edge, all valid bits and data registers go to 0. flush has priority over en. The configuration registers are unchanged.
- Configuration registers: mode_q and signed_q.
  - Effective config is the live inputs when busy=0, and mode_q/signed_q when busy=1.
  - mode_q and signed_q load the live inputs on every edge where busy=0.
  - Consequence: a beat accepted while idle uses that cycle's inputs, and config changes while busy have no effect.
- Extension is applied at lane input, before the delay line. Storage is DW_OUT bits per stage.
- out_data lane k is 0 whenever out_valid[k]=0.
- busy is the OR of all valid bits in the delay lines and output registers. It is registered-state derived, with no combinational path from in_valid.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, mode_q=0, signed_q=1, all delay stages 0.
- Latency of lane k is d_k+1 en-qualified cycles. Stalled cycles do not count.
- Skew mode, CH_NUM=9: lane 0 appears 1 cycle after acceptance and lane 8 appears 9 cycles after.
- A single beat fully drains CH_NUM en-cycles after acceptance. busy falls on the edge where the last valid bit leaves out_valid.
- Back-to-back beats (in_valid held high, en=1) give full throughput, one beat per cycle per lane.
- flush and in_valid in the same cycle: the beat is dropped and busy=0 afterward.
- en=0 and flush=1 in the same cycle: flush still clears.
- rstn asserted mid-stream: asynchronous clear to reset values. There is no partial output.

## Structure
- Shared package/header conv_pre_pkg:
  - lane-extension function ext(data, signed), DW_IN→DW_OUT;
  - mode encodings SKEW=0, DESKEW=1.
- Sub-module skew_delay_line:
  - one lane of depth CH_NUM-1;
  - runtime tap select 0..CH_NUM-1 (tap 0 = bypass);
  - carries valid alongside data;
  - shares the en and flush ports.
- Top: generate loop of CH_NUM skew_delay_line instances, config latch, output registers, busy reduction.

## Test plan
- Skew, signed, CH_NUM=9: accept one beat with all lanes = 8'h80, then bubbles -> lane k out_valid pulses at cycle k+1 with data 9'h180, and busy clears after cycle 9.
- Deskew, unsigned: accept a beat with lane k = k+1 -> lane 8 at cycle 1, lane 0 at cycle 9, data zero-extended (lane 0 = 9'h001).
- Stream 20 beats with data = beat index, toggling en low for 3 cycles mid-stream -> per-lane sequences have no gaps or duplicates, and latency counted in en-cycles equals d_k+1.
- Assert flush while 4 beats are in flight, with in_valid=1 the same cycle -> all out_valid=0 next cycle, busy=0, and no later output.
- Toggle cfg_deskew while busy=1 -> output order is unchanged until drain. Toggle while idle, then accept a beat the same cycle -> that beat uses the new mode.
- Assert rstn low during streaming -> outputs immediately 0 and mode_q=0, signed_q=1 after release.
